// File: rtl/hash_pkg.sv
// ----------------------------------------------------------------------------
// hash_pkg
// Definitions shared by the toy hash core and its nonce-search initiator:
// block and digest widths, the search-controller state encoding, and the
// digest initial-value bytes used by the hash core.
// ----------------------------------------------------------------------------
package hash_pkg;

    localparam int HASH_BLK_W = 128;
    localparam int HASH_DIG_W = 24;

    // Initial digest bytes {H0,H1,H2} loaded by the hash core per block
    localparam logic [7:0] HASH_H0 = 8'h6A;
    localparam logic [7:0] HASH_H1 = 8'hBB;
    localparam logic [7:0] HASH_H2 = 8'h3C;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/digest_meets_target.sv
// ----------------------------------------------------------------------------
// digest_meets_target
// Combinational pass test for one digest: both of the two most significant
// digest bytes must be strictly below the target (unsigned).
// Ports:
//   digest_top  in  16  top two digest bytes {H0,H1}
//   target      in  8   threshold; 0 can never pass
//   pass        out 1   1 when both bytes are below target
// ----------------------------------------------------------------------------
module digest_meets_target
    import hash_pkg::*;
(
    input  logic [15:0] digest_top,
    input  logic [7:0]  target,
    output logic        pass
);

    // Both-byte unsigned compare against the threshold
    always_comb begin
        pass = 1'b0;
        if ((digest_top[15:8] < target) && (digest_top[7:0] < target)) begin
            pass = 1'b1;
        end else begin
            pass = 1'b0;
        end
    end

endmodule

// File: rtl/nonce_search_ctrl.sv
// ----------------------------------------------------------------------------
// nonce_search_ctrl
// Host-side initiator for the 24-bit toy hash core. Latches a header and
// target, then walks nonces from nonce_first to nonce_last, launching one
// {header, nonce} block per hash request, until a digest passes, the range
// is exhausted, the host aborts, or the core fails to answer in time.
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-high reset
//   start, abort       host control: start pulse (IDLE only), abort level
//   header, target     search inputs, sampled on accepted start
//   nonce_first/last   inclusive nonce range (may wrap), sampled on start
//   hash_start         1-cycle request to the hash core
//   hash_block         {header, nonce}, held while the core works
//   hash_done/digest   core response, digest valid with done
//   busy               high whenever not IDLE
//   found/exhausted/timeout_err  1-cycle completion pulses
//   nonce_out/digest_out         passing result, held until next start
//   attempts           digests checked since the last accepted start
// ----------------------------------------------------------------------------
module nonce_search_ctrl
    import hash_pkg::*;
#(
    parameter int HDR_W       = 96,
    parameter int NONCE_W     = 32,
    parameter int DIG_W       = 24,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [HDR_W-1:0]      header,
    input  logic [7:0]            target,
    input  logic [NONCE_W-1:0]    nonce_first,
    input  logic [NONCE_W-1:0]    nonce_last,
    output logic                  hash_start,
    output logic [HASH_BLK_W-1:0] hash_block,
    input  logic                  hash_done,
    input  logic [DIG_W-1:0]      hash_digest,
    output logic                  busy,
    output logic                  found,
    output logic                  exhausted,
    output logic                  timeout_err,
    output logic [NONCE_W-1:0]    nonce_out,
    output logic [DIG_W-1:0]      digest_out,
    output logic [NONCE_W-1:0]    attempts
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t              state_r;
    logic [HDR_W-1:0]    header_r;
    logic [7:0]          target_r;
    logic [NONCE_W-1:0]  nonce_r;
    logic [NONCE_W-1:0]  last_r;
    logic [DIG_W-1:0]    digest_r;
    // Cycles elapsed since hash_start was asserted for the current block
    logic [CNT_W-1:0]    wait_cnt_r;
    logic                pass_s;

    digest_meets_target u_cmp (
        .digest_top (digest_r[DIG_W-1 -: 16]),
        .target     (target_r),
        .pass       (pass_s)
    );

    // Block registers feed the core directly, so they stay stable while it works
    assign hash_block = {header_r, nonce_r};

    // Search FSM with counters and registered pulse/status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            header_r    <= '0;
            target_r    <= 8'h00;
            nonce_r     <= '0;
            last_r      <= '0;
            digest_r    <= '0;
            wait_cnt_r  <= '0;
            hash_start  <= 1'b0;
            busy        <= 1'b0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            timeout_err <= 1'b0;
            nonce_out   <= '0;
            digest_out  <= '0;
            attempts    <= '0;
        end else begin
            hash_start  <= 1'b0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            timeout_err <= 1'b0;
            if (abort) begin
                // Abort beats everything, including a same-edge start;
                // results stay visible and no completion pulse is raised.
                state_r <= ST_IDLE;
                busy    <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            header_r   <= header;
                            target_r   <= target;
                            nonce_r    <= nonce_first;
                            last_r     <= nonce_last;
                            nonce_out  <= '0;
                            digest_out <= '0;
                            attempts   <= '0;
                            wait_cnt_r <= '0;
                            hash_start <= 1'b1;
                            busy       <= 1'b1;
                            state_r    <= ST_ISSUE;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_ISSUE: begin
                        // The request cycle itself counts toward the timeout
                        wait_cnt_r <= CNT_W'(1);
                        state_r    <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (hash_done) begin
                            digest_r <= hash_digest;
                            state_r  <= ST_CHECK;
                        end else if (wait_cnt_r == CNT_W'(TIMEOUT_CYC - 1)) begin
                            // Pulse lands exactly TIMEOUT_CYC cycles after hash_start
                            timeout_err <= 1'b1;
                            state_r     <= ST_DONE;
                        end else begin
                            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                        end
                    end
                    ST_CHECK: begin
                        attempts <= attempts + NONCE_W'(1);
                        if (pass_s) begin
                            found      <= 1'b1;
                            nonce_out  <= nonce_r;
                            digest_out <= digest_r;
                            state_r    <= ST_DONE;
                        end else if (nonce_r == last_r) begin
                            exhausted <= 1'b1;
                            state_r   <= ST_DONE;
                        end else begin
                            // Natural wrap lets a range cross 2^NONCE_W-1
                            nonce_r    <= nonce_r + NONCE_W'(1);
                            wait_cnt_r <= '0;
                            hash_start <= 1'b1;
                            state_r    <= ST_ISSUE;
                        end
                    end
                    ST_DONE: begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// ----------------------------------------------------------------------------
// tb_nonce_search_ctrl
// Scoreboard bench for nonce_search_ctrl. Stimulus pushes the expected
// hash blocks and the expected completion record; a monitor pops and compares
// on every hash_start and every completion pulse. A scripted hash-core model
// answers each request with a digest chosen by nonce after a set latency.
// ----------------------------------------------------------------------------
module tb_nonce_search_ctrl;

    logic         clk;
    logic         reset;
    logic         start;
    logic         abort;
    logic [95:0]  header;
    logic [7:0]   target;
    logic [31:0]  nonce_first;
    logic [31:0]  nonce_last;
    logic         hash_start;
    logic [127:0] hash_block;
    logic         hash_done;
    logic [23:0]  hash_digest;
    logic         busy;
    logic         found;
    logic         exhausted;
    logic         timeout_err;
    logic [31:0]  nonce_out;
    logic [23:0]  digest_out;
    logic [31:0]  attempts;

    localparam logic [2:0] K_FOUND = 3'b100;
    localparam logic [2:0] K_EXH   = 3'b010;
    localparam logic [2:0] K_TMO   = 3'b001;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] nonce;
        logic [23:0] dig;
        logic [31:0] att;
    } res_t;

    int           total = 0;
    int           bad   = 0;
    int           scen  = 1;
    int           lat   = 2;
    bit           model_silent = 1'b0;
    logic [127:0] exp_blk_q[$];
    res_t         exp_res_q[$];
    res_t         mon_r;

    nonce_search_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .header      (header),
        .target      (target),
        .nonce_first (nonce_first),
        .nonce_last  (nonce_last),
        .hash_start  (hash_start),
        .hash_block  (hash_block),
        .hash_done   (hash_done),
        .hash_digest (hash_digest),
        .busy        (busy),
        .found       (found),
        .exhausted   (exhausted),
        .timeout_err (timeout_err),
        .nonce_out   (nonce_out),
        .digest_out  (digest_out),
        .attempts    (attempts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scripted digests, hand-chosen against target 0x10 for scenario 1
    function automatic logic [23:0] digest_for(input int s, input logic [31:0] n);
        logic [23:0] d;
        d = 24'hFFFFFF;
        if (s == 1) begin
            case (n)
                32'd0:   d = 24'h200500;  // H0 too big
                32'd1:   d = 24'h053000;  // H1 too big
                32'd2:   d = 24'h100F00;  // H0 equal to target: not below
                32'd3:   d = 24'h0F0F00;  // passes
                default: d = 24'hFFFFFF;
            endcase
        end else if (s == 2) begin
            d = 24'h000000;               // zero digest still fails target 0
        end else begin
            d = 24'hFFFFFF;
        end
        return d;
    endfunction

    // Hash core model: answer each request after lat cycles unless silenced
    initial begin
        logic [127:0] blk;
        hash_done   = 1'b0;
        hash_digest = 24'h000000;
        forever begin
            @(negedge clk);
            if (hash_start && !model_silent) begin
                blk = hash_block;
                repeat (lat) @(negedge clk);
                check("block_stable", hash_block, blk);
                hash_digest = digest_for(scen, blk[31:0]);
                hash_done   = 1'b1;
                @(negedge clk);
                hash_done   = 1'b0;
            end
        end
    end

    // Monitor: compare every request block and every completion pulse
    always @(negedge clk) begin
        if (hash_start) begin
            check("blk_expected", 128'(exp_blk_q.size() != 0), 128'(1'b1));
            if (exp_blk_q.size() != 0) begin
                check("hash_block", hash_block, exp_blk_q.pop_front());
            end
        end
        if (found || exhausted || timeout_err) begin
            check("res_expected", 128'(exp_res_q.size() != 0), 128'(1'b1));
            if (exp_res_q.size() != 0) begin
                mon_r = exp_res_q.pop_front();
                check("res_kind",   128'({found, exhausted, timeout_err}), 128'(mon_r.kind));
                check("nonce_out",  128'(nonce_out),  128'(mon_r.nonce));
                check("digest_out", 128'(digest_out), 128'(mon_r.dig));
                check("attempts",   128'(attempts),   128'(mon_r.att));
            end
        end
    end

    task automatic do_start(input logic [95:0] h, input logic [7:0] t,
                            input logic [31:0] f, input logic [31:0] l);
        @(negedge clk);
        header      = h;
        target      = t;
        nonce_first = f;
        nonce_last  = l;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(nm, 128'(ok), 128'(1'b1));
    endtask

    task automatic wait_hash_start(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (hash_start) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(nm, 128'(ok), 128'(1'b1));
    endtask

    task automatic push_expect(input logic [95:0] h, input logic [31:0] f, input int nblk,
                               input logic [2:0] kind, input logic [31:0] no,
                               input logic [23:0] dg, input logic [31:0] att);
        res_t r;
        logic [31:0] n;
        n = f;
        for (int i = 0; i < nblk; i++) begin
            exp_blk_q.push_back({h, n});
            n = n + 32'd1;
        end
        r.kind = kind; r.nonce = no; r.dig = dg; r.att = att;
        exp_res_q.push_back(r);
    endtask

    // Directed scenarios
    initial begin
        int k;
        int ndone;
        logic [95:0] hdr_a;
        hdr_a       = {12{8'hA5}};
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        header      = 96'h0;
        target      = 8'h00;
        nonce_first = 32'h0;
        nonce_last  = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy",       128'(busy),        128'(1'b0));
        check("rst_hash_start", 128'(hash_start),  128'(1'b0));
        check("rst_hash_block", hash_block,        128'h0);
        check("rst_pulses",     128'({found, exhausted, timeout_err}), 128'(3'b000));
        check("rst_results",    128'({nonce_out, digest_out, attempts}), 128'h0);

        // 1: pass on nonce 3
        scen = 1;
        push_expect(hdr_a, 32'd0, 4, K_FOUND, 32'd3, 24'h0F0F00, 32'd4);
        do_start(hdr_a, 8'h10, 32'd0, 32'd9);
        wait_idle("s1_idle", 300);

        // 2: target 0 never passes, whole range runs
        scen = 2;
        push_expect(96'h0123456789ABCDEF00112233, 32'd5, 3, K_EXH, 32'd0, 24'h000000, 32'd3);
        do_start(96'h0123456789ABCDEF00112233, 8'h00, 32'd5, 32'd7);
        wait_idle("s2_idle", 300);
        check("s2_result_kept", 128'(attempts), 128'(32'd3));

        // 3: range wraps FFFFFFFE, FFFFFFFF, 0, 1
        scen = 3;
        push_expect(96'hDEADBEEF00000000CAFEF00D, 32'hFFFFFFFE, 4, K_EXH, 32'd0, 24'h000000, 32'd4);
        do_start(96'hDEADBEEF00000000CAFEF00D, 8'h10, 32'hFFFFFFFE, 32'd1);
        wait_idle("s3_idle", 300);

        // 4: core never answers
        model_silent = 1'b1;
        push_expect(96'h111122223333444455556666, 32'd100, 1, K_TMO, 32'd0, 24'h000000, 32'd0);
        do_start(96'h111122223333444455556666, 8'h10, 32'd100, 32'd200);
        wait_hash_start("s4_hash_start");
        k = 0;
        while (!timeout_err && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("s4_timeout_latency", 128'(k), 128'(64));
        check("s4_busy_at_pulse", 128'(busy), 128'(1'b1));
        @(negedge clk);
        check("s4_busy_dropped", 128'(busy), 128'(1'b0));
        model_silent = 1'b0;

        // 5: abort in WAIT, late done must be ignored
        scen = 1;
        lat  = 4;
        exp_blk_q.push_back({96'h0, 32'd0});
        do_start(96'h0, 8'h10, 32'd0, 32'd9);
        wait_hash_start("s5_hash_start");
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("s5_busy_after_abort", 128'(busy), 128'(1'b0));
        repeat (6) @(negedge clk);
        check("s5_busy_after_late_done", 128'(busy), 128'(1'b0));
        check("s5_attempts_kept", 128'(attempts), 128'(32'd0));
        lat = 2;
        push_expect(96'h0, 32'd0, 4, K_FOUND, 32'd3, 24'h0F0F00, 32'd4);
        do_start(96'h0, 8'h10, 32'd0, 32'd9);
        wait_idle("s5_rerun_idle", 300);

        // Same-edge start and abort in IDLE: start dropped
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("start_abort_busy", 128'(busy), 128'(1'b0));
        check("start_abort_nonce_out", 128'(nonce_out), 128'(32'd3));

        // 6: asynchronous reset while in CHECK of the second attempt
        scen = 1;
        push_expect(hdr_a, 32'd0, 4, K_FOUND, 32'd3, 24'h0F0F00, 32'd4);
        do_start(hdr_a, 8'h10, 32'd0, 32'd9);
        ndone = 0;
        for (int i = 0; i < 200 && ndone < 2; i++) begin
            @(posedge clk);
            if (hash_done) ndone++;
        end
        check("s6_reached_check", 128'(ndone), 128'(2));
        #2;
        reset = 1'b1;
        #1;
        check("s6_busy",       128'(busy),       128'(1'b0));
        check("s6_hash_block", hash_block,       128'h0);
        check("s6_attempts",   128'(attempts),   128'(32'd0));
        check("s6_outs",       128'({hash_start, nonce_out, digest_out}), 128'h0);
        exp_blk_q.delete();
        exp_res_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        push_expect(hdr_a, 32'd0, 4, K_FOUND, 32'd3, 24'h0F0F00, 32'd4);
        do_start(hdr_a, 8'h10, 32'd0, 32'd9);
        wait_idle("s6_rerun_idle", 300);

        repeat (2) @(negedge clk);
        check("blk_q_drained", 128'(exp_blk_q.size()), 128'(0));
        check("res_q_drained", 128'(exp_res_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
